// File: rtl/vcu_pkg.sv
// vcu_pkg: shared definitions for the video-control-unit peripheral.
//   - control word bit positions (vcu_reg_control)
//   - status word bit positions (vcu_reg_rdata)
//   - FIFO entry type
package vcu_pkg;

   localparam int VCU_CTL_RESTART = 0;
   localparam int VCU_CTL_FLUSH   = 1;
   localparam int VCU_CTL_CLR_OVF = 2;

   localparam int VCU_ST_TICK     = 0;
   localparam int VCU_ST_FULL     = 1;
   localparam int VCU_ST_EMPTY    = 2;
   localparam int VCU_ST_OVF      = 3;
   localparam int VCU_ST_CNT_LSB  = 4;

   typedef logic [15:0] vcu_entry_t;

endpackage

// File: rtl/vcu_sync_fifo.sv
// vcu_sync_fifo: single-clock FIFO with push/pop/flush and occupancy count.
//   clk, reset_p      clock, asynchronous active-high reset
//   push_i, wdata_i   write request and data
//   pop_i             read request (ignored when empty)
//   flush_i           discard all entries; beats push and pop in the same cycle
//   head_o            entry at the read pointer (valid when !empty_o)
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries, 0..DEPTH
module vcu_sync_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset_p,
   input  logic              push_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              pop_i,
   input  logic              flush_i,
   output logic [DATA_W-1:0] head_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [CNT_W-1:0]  count_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A push into a full FIFO is still accepted when a pop frees a slot
   // in the same cycle.
   assign do_pop  = pop_i && !empty_o && !flush_i;
   assign do_push = push_i && !flush_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
         else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset: the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/vcu_periph.sv
// vcu_periph: CPU-facing video-control-unit peripheral.
// Buffers CPU data writes in a FIFO, drains one entry per DRAIN_DIV cycles
// onto a registered display bus, runs a restartable countdown timer and
// reports status back to the CPU.
//   clk, reset_p          clock, asynchronous active-high reset
//   vcu_reg_control(_we)  control word: [0] timer restart, [1] FIFO flush,
//                         [2] clear overflow
//   vcu_reg_wdata(_we)    data word; [15:0] pushed into the FIFO
//   vcu_reg_rdata         status: [0] tick_done, [1] full, [2] empty,
//                         [3] overflow, [8:4] count
//   disp_data, disp_valid last drained entry and its one-cycle update pulse
module vcu_periph
   import vcu_pkg::*;
#(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [27:0] TICK_LOAD  = 28'h2FAF080,
   parameter logic [15:0] DRAIN_DIV  = 16'd50000
) (
   input  logic        clk,
   input  logic        reset_p,
   input  logic [31:0] vcu_reg_control,
   input  logic        vcu_reg_control_we,
   input  logic [31:0] vcu_reg_wdata,
   input  logic        vcu_reg_wdata_we,
   output logic [31:0] vcu_reg_rdata,
   output logic [15:0] disp_data,
   output logic        disp_valid
);

   localparam int          CNT_W        = $clog2(FIFO_DEPTH + 1);
   localparam logic [15:0] DRAIN_RELOAD = DRAIN_DIV - 16'd1;

   logic ctl_restart, ctl_flush, ctl_clr_ovf;
   logic fifo_full, fifo_empty, pop_req;
   logic [CNT_W-1:0] fifo_count;
   vcu_entry_t       fifo_head;

   logic [27:0] timer_q, timer_d;
   logic [15:0] drain_q, drain_d;
   logic        ovf_q, ovf_d;
   vcu_entry_t  disp_data_q, disp_data_d;
   logic        disp_valid_q, disp_valid_d;

   // Only the three defined control bits and the low data half are used.
   logic unused_bits;
   assign unused_bits = ^{vcu_reg_control[31:3], vcu_reg_wdata[31:16]};

   assign ctl_restart = vcu_reg_control_we && vcu_reg_control[VCU_CTL_RESTART];
   assign ctl_flush   = vcu_reg_control_we && vcu_reg_control[VCU_CTL_FLUSH];
   assign ctl_clr_ovf = vcu_reg_control_we && vcu_reg_control[VCU_CTL_CLR_OVF];

   // Flush takes priority over a pending pop.
   assign pop_req = (drain_q == 16'd0) && !fifo_empty && !ctl_flush;

   vcu_sync_fifo #(
      .DATA_W (16),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_p (reset_p),
      .push_i  (vcu_reg_wdata_we),
      .wdata_i (vcu_reg_wdata[15:0]),
      .pop_i   (pop_req),
      .flush_i (ctl_flush),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      timer_d      = timer_q;
      drain_d      = drain_q;
      ovf_d        = ovf_q;
      disp_data_d  = disp_data_q;
      disp_valid_d = 1'b0;

      if (ctl_restart)          timer_d = TICK_LOAD;
      else if (timer_q != '0)   timer_d = timer_q - 28'd1;

      if (pop_req) begin
         drain_d      = DRAIN_RELOAD;
         disp_data_d  = fifo_head;
         disp_valid_d = 1'b1;
      end else if (drain_q != 16'd0) begin
         drain_d = drain_q - 16'd1;
      end

      // A dropped write in the same cycle as a clear re-arms the flag.
      if (ctl_clr_ovf) ovf_d = 1'b0;
      if (vcu_reg_wdata_we && !ctl_flush && fifo_full && !pop_req) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         timer_q      <= TICK_LOAD;
         drain_q      <= 16'd0;
         ovf_q        <= 1'b0;
         disp_data_q  <= '0;
         disp_valid_q <= 1'b0;
      end else begin
         timer_q      <= timer_d;
         drain_q      <= drain_d;
         ovf_q        <= ovf_d;
         disp_data_q  <= disp_data_d;
         disp_valid_q <= disp_valid_d;
      end
   end

   assign disp_data  = disp_data_q;
   assign disp_valid = disp_valid_q;

   always_comb begin
      vcu_reg_rdata                                = '0;
      vcu_reg_rdata[VCU_ST_TICK]                   = (timer_q == '0);
      vcu_reg_rdata[VCU_ST_FULL]                   = fifo_full;
      vcu_reg_rdata[VCU_ST_EMPTY]                  = fifo_empty;
      vcu_reg_rdata[VCU_ST_OVF]                    = ovf_q;
      vcu_reg_rdata[VCU_ST_CNT_LSB+4:VCU_ST_CNT_LSB] = 5'(fifo_count);
   end

endmodule
